// File: rtl/riscv_defines.sv
// Shared core definitions.
//   RISCV_ADDR_WIDTH : width of instruction/data addresses
//   RISCV_WORD_WIDTH : width of a fetched instruction word
//   fetch_state_e    : instruction fetch controller state
package riscv_defines;

    localparam int unsigned RISCV_ADDR_WIDTH = 32;
    localparam int unsigned RISCV_WORD_WIDTH = 32;

    // StLockedRedirect: a redirect is waiting behind a request that has not been granted yet.
    typedef enum logic [0:0] {
        StRun,
        StLockedRedirect
    } fetch_state_e;

endpackage

// File: rtl/fetch_skid_fifo.sv
// Small in-order FIFO with a synchronous flush.
//   clk, rst_n   : clock, asynchronous active-low reset
//   flush_i      : drop all entries (takes priority over push/pop)
//   push_i       : write push_data_i (accepted when not full, or when popping while full)
//   pop_i        : remove the head entry (ignored when empty)
//   head_o       : current head entry
//   count_o      : number of stored entries
//   empty_o      : no entries stored
//   full_o       : DEPTH entries stored
module fetch_skid_fifo #(
    parameter int unsigned DEPTH = 2,
    parameter int unsigned WIDTH = 32,
    localparam int unsigned PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1,
    localparam int unsigned CNT_W = $clog2(DEPTH + 1)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             flush_i,
    input  logic             push_i,
    input  logic [WIDTH-1:0] push_data_i,
    input  logic             pop_i,
    output logic [WIDTH-1:0] head_o,
    output logic [CNT_W-1:0] count_o,
    output logic             empty_o,
    output logic             full_o
);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [PTR_W-1:0] wr_ptr_q, rd_ptr_q;
    logic [CNT_W-1:0] count_q;
    logic             do_push, do_pop;

    function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
        return (p == PTR_W'(DEPTH - 1)) ? '0 : p + PTR_W'(1);
    endfunction

    assign empty_o = (count_q == '0);
    assign full_o  = (count_q == CNT_W'(DEPTH));
    assign count_o = count_q;
    assign head_o  = mem_q[rd_ptr_q];

    assign do_pop  = pop_i & ~empty_o;
    assign do_push = push_i & (~full_o | do_pop);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else if (flush_i) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (do_push) wr_ptr_q <= ptr_inc(wr_ptr_q);
            if (do_pop)  rd_ptr_q <= ptr_inc(rd_ptr_q);
            if (do_push && !do_pop) begin
                count_q <= count_q + CNT_W'(1);
            end else if (!do_push && do_pop) begin
                count_q <= count_q - CNT_W'(1);
            end
        end
    end

    // Storage needs no reset; entries are only read once counted.
    always_ff @(posedge clk) begin
        if (do_push && !flush_i) begin
            mem_q[wr_ptr_q] <= push_data_i;
        end
    end

endmodule

// File: rtl/instr_fetch_ctrl.sv
// Instruction fetch controller: owns the fetch address, issues word requests on a
// req/gnt/rvalid bus and feeds responses into the realign buffer.
//   clk, rst_n          : clock, asynchronous active-low reset
//   redirect_i/_addr_i  : one-cycle restart of fetch at a new (halfword-aligned) target
//   instr_req_o/addr_o  : memory request and word-aligned address
//   instr_gnt_i         : request accepted
//   instr_rvalid_i/rdata: in-order response
//   buf_clear_o         : clear realign buffer
//   buf_read_offset_o   : starting halfword offset for the buffer
//   buf_write_en_o      : push buf_instr_o / buf_addr_o into the buffer
//   buf_full_i          : buffer cannot accept a push
module instr_fetch_ctrl
    import riscv_defines::*;
#(
    parameter logic [RISCV_ADDR_WIDTH-1:0] BOOT_ADDR       = 32'h0000_0000,
    parameter int unsigned                 MAX_OUTSTANDING = 2
) (
    input  logic                        clk,
    input  logic                        rst_n,
    input  logic                        redirect_i,
    input  logic [RISCV_ADDR_WIDTH-1:0] redirect_addr_i,
    output logic                        instr_req_o,
    output logic [RISCV_ADDR_WIDTH-1:0] instr_addr_o,
    input  logic                        instr_gnt_i,
    input  logic                        instr_rvalid_i,
    input  logic [RISCV_WORD_WIDTH-1:0] instr_rdata_i,
    output logic                        buf_clear_o,
    output logic                        buf_read_offset_o,
    output logic                        buf_write_en_o,
    output logic [RISCV_WORD_WIDTH-1:0] buf_instr_o,
    output logic [RISCV_ADDR_WIDTH-1:0] buf_addr_o,
    input  logic                        buf_full_i
);

    localparam int unsigned AW    = RISCV_ADDR_WIDTH;
    localparam int unsigned WW    = RISCV_WORD_WIDTH;
    localparam int unsigned CNT_W = $clog2(MAX_OUTSTANDING + 1);
    localparam int unsigned SUM_W = CNT_W + 1;

    fetch_state_e      state_q, state_d;
    logic [AW-1:0]     fetch_addr_q, fetch_addr_d;
    logic [AW-1:0]     target_q, target_d;
    logic              req_locked_q, req_locked_d;
    logic [CNT_W-1:0]  outstanding_q, outstanding_d;
    logic [CNT_W-1:0]  discard_q, discard_d;

    logic [AW-1:0]     redirect_word;
    logic              room;
    logic              gnt_acc;
    logic              drop, deliver, bypass, head_push, skid_push;

    logic [WW+AW-1:0]  skid_head;
    logic [CNT_W-1:0]  skid_count;
    logic              skid_empty, skid_full;
    logic [AW-1:0]     rsp_addr;
    logic [CNT_W-1:0]  aq_count;
    logic              aq_empty, aq_full;
    logic              unused_sigs;

    assign redirect_word = {redirect_addr_i[AW-1:2], 2'b00};

    // Skid entries count against the budget so every response always has a home.
    assign room = (SUM_W'(outstanding_q) + SUM_W'(skid_count)) < SUM_W'(MAX_OUTSTANDING);

    assign instr_req_o  = rst_n & (req_locked_q | (~redirect_i & room));
    assign instr_addr_o = fetch_addr_q;
    assign gnt_acc      = instr_req_o & instr_gnt_i;

    assign drop      = instr_rvalid_i & ((discard_q != '0) | redirect_i);
    assign deliver   = instr_rvalid_i & ~drop;
    assign head_push = ~skid_empty & ~buf_full_i & ~redirect_i;
    assign bypass    = deliver & skid_empty & ~buf_full_i;
    assign skid_push = deliver & ~bypass;

    assign buf_write_en_o    = rst_n & (head_push | bypass);
    assign buf_instr_o       = skid_empty ? instr_rdata_i : skid_head[WW+AW-1:AW];
    assign buf_addr_o        = skid_empty ? rsp_addr : skid_head[AW-1:0];
    assign buf_clear_o       = redirect_i;
    assign buf_read_offset_o = redirect_i ? redirect_addr_i[1] : BOOT_ADDR[1];

    // Address of every granted request, popped as its response returns.
    fetch_skid_fifo #(
        .DEPTH (MAX_OUTSTANDING),
        .WIDTH (AW)
    ) u_addr_queue (
        .clk         (clk),
        .rst_n       (rst_n),
        .flush_i     (1'b0),
        .push_i      (gnt_acc),
        .push_data_i (instr_addr_o),
        .pop_i       (instr_rvalid_i),
        .head_o      (rsp_addr),
        .count_o     (aq_count),
        .empty_o     (aq_empty),
        .full_o      (aq_full)
    );

    fetch_skid_fifo #(
        .DEPTH (MAX_OUTSTANDING),
        .WIDTH (WW + AW)
    ) u_skid (
        .clk         (clk),
        .rst_n       (rst_n),
        .flush_i     (redirect_i),
        .push_i      (skid_push),
        .push_data_i ({instr_rdata_i, rsp_addr}),
        .pop_i       (head_push),
        .head_o      (skid_head),
        .count_o     (skid_count),
        .empty_o     (skid_empty),
        .full_o      (skid_full)
    );

    assign unused_sigs = ^{aq_count, aq_empty, aq_full, skid_full, redirect_addr_i[0]};

    always_comb begin
        state_d       = state_q;
        fetch_addr_d  = fetch_addr_q;
        target_d      = target_q;
        req_locked_d  = req_locked_q;
        outstanding_d = outstanding_q;
        discard_d     = discard_q;

        if (gnt_acc) begin
            req_locked_d = 1'b0;
        end else if (instr_req_o) begin
            req_locked_d = 1'b1;
        end

        if (gnt_acc && !instr_rvalid_i) begin
            outstanding_d = outstanding_q + CNT_W'(1);
        end else if (!gnt_acc && instr_rvalid_i) begin
            outstanding_d = outstanding_q - CNT_W'(1);
        end

        if (instr_rvalid_i && (discard_q != '0)) begin
            discard_d = discard_q - CNT_W'(1);
        end

        unique case (state_q)
            StRun: begin
                if (redirect_i) begin
                    if (req_locked_q && !gnt_acc) begin
                        state_d  = StLockedRedirect;
                        target_d = redirect_word;
                    end else begin
                        fetch_addr_d = redirect_word;
                    end
                end else if (gnt_acc) begin
                    fetch_addr_d = fetch_addr_q + AW'(4);
                end
            end
            StLockedRedirect: begin
                if (redirect_i) begin
                    target_d = redirect_word;
                end
                if (gnt_acc) begin
                    // The held request belongs to the old stream: its response is stale.
                    state_d      = StRun;
                    fetch_addr_d = redirect_i ? redirect_word : target_q;
                    discard_d    = discard_d + CNT_W'(1);
                end
            end
            default: state_d = StRun;
        endcase

        // Everything still in flight after a redirect cycle belongs to the old stream.
        if (redirect_i) begin
            discard_d = outstanding_d;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q       <= StRun;
            fetch_addr_q  <= {BOOT_ADDR[AW-1:2], 2'b00};
            target_q      <= '0;
            req_locked_q  <= 1'b0;
            outstanding_q <= '0;
            discard_q     <= '0;
        end else begin
            state_q       <= state_d;
            fetch_addr_q  <= fetch_addr_d;
            target_q      <= target_d;
            req_locked_q  <= req_locked_d;
            outstanding_q <= outstanding_d;
            discard_q     <= discard_d;
        end
    end

endmodule

// File: tb/tb_instr_fetch_ctrl.sv
module tb_instr_fetch_ctrl;
    import riscv_defines::*;

    localparam logic [31:0] BOOT = 32'h0000_0100;
    localparam int          MAXO = 2;

    logic        clk, rst_n;
    logic        redirect_i;
    logic [31:0] redirect_addr_i;
    logic        instr_req_o;
    logic [31:0] instr_addr_o;
    logic        instr_gnt_i, instr_rvalid_i;
    logic [31:0] instr_rdata_i;
    logic        buf_clear_o, buf_read_offset_o, buf_write_en_o;
    logic [31:0] buf_instr_o, buf_addr_o;
    logic        buf_full_i;

    instr_fetch_ctrl #(
        .BOOT_ADDR       (BOOT),
        .MAX_OUTSTANDING (MAXO)
    ) dut (
        .clk               (clk),
        .rst_n             (rst_n),
        .redirect_i        (redirect_i),
        .redirect_addr_i   (redirect_addr_i),
        .instr_req_o       (instr_req_o),
        .instr_addr_o      (instr_addr_o),
        .instr_gnt_i       (instr_gnt_i),
        .instr_rvalid_i    (instr_rvalid_i),
        .instr_rdata_i     (instr_rdata_i),
        .buf_clear_o       (buf_clear_o),
        .buf_read_offset_o (buf_read_offset_o),
        .buf_write_en_o    (buf_write_en_o),
        .buf_instr_o       (buf_instr_o),
        .buf_addr_o        (buf_addr_o),
        .buf_full_i        (buf_full_i)
    );

    typedef struct { logic [31:0] addr; bit stale; } pend_t;
    typedef struct { logic [31:0] addr; logic [31:0] data; } exp_t;

    pend_t       pend_q[$];   // granted requests awaiting a response
    exp_t        exp_q[$];    // delivered responses awaiting a buffer push
    int          checks = 0;
    int          errors = 0;
    bit          gnt_en, rvalid_en, full_en;
    logic [31:0] exp_addr, pend_tgt;
    bit          pend_tgt_v, locked_m;
    bit          last_req, last_wr;
    logic [31:0] last_req_addr, last_wr_addr, last_wr_data;
    int          wr_count;

    function automatic logic [31:0] mem_data(input logic [31:0] a);
        return {a[15:0], ~a[31:16]} ^ 32'h5A5A_0F0F;
    endfunction

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // One bus cycle: drive inputs, check outputs mid-cycle against the bench model, then
    // advance to just after the next rising edge.
    task automatic tick(input bit redir, input logic [31:0] raddr);
        pend_t p;
        exp_t  e;
        bit    exp_req, exp_wr, acc, exp_ofs;
        redirect_i      = redir;
        redirect_addr_i = raddr;
        instr_gnt_i     = gnt_en;
        buf_full_i      = full_en;
        if (rvalid_en && pend_q.size() > 0) begin
            instr_rvalid_i = 1'b1;
            instr_rdata_i  = mem_data(pend_q[0].addr);
        end else begin
            instr_rvalid_i = 1'b0;
            instr_rdata_i  = 32'h0;
        end
        #4;
        exp_req = locked_m || (!redir && (pend_q.size() + exp_q.size() < MAXO));
        checks++;
        if (instr_req_o !== exp_req) begin
            errors++;
            $display("FAIL req_issue: got %b expected %b at %0t", instr_req_o, exp_req, $time);
        end
        if (instr_req_o === 1'b1) begin
            checks++;
            if (instr_addr_o !== exp_addr) begin
                errors++;
                $display("FAIL req_addr: got %h expected %h at %0t", instr_addr_o, exp_addr,
                         $time);
            end
        end
        exp_ofs = redir ? raddr[1] : BOOT[1];
        checks++;
        if (buf_clear_o !== redir || buf_read_offset_o !== exp_ofs) begin
            errors++;
            $display("FAIL clear_offset: got %b/%b expected %b/%b at %0t", buf_clear_o,
                     buf_read_offset_o, redir, exp_ofs, $time);
        end
        acc      = (instr_req_o === 1'b1) && gnt_en;
        locked_m = (instr_req_o === 1'b1) && !gnt_en;
        if (instr_rvalid_i) begin
            p = pend_q.pop_front();
            if (!p.stale && !redir) begin
                e.addr = p.addr;
                e.data = mem_data(p.addr);
                exp_q.push_back(e);
            end
        end
        if (redir) begin
            exp_q.delete();
            foreach (pend_q[i]) pend_q[i].stale = 1'b1;
        end
        exp_wr = !redir && !full_en && exp_q.size() > 0;
        checks++;
        if (buf_write_en_o !== exp_wr) begin
            errors++;
            $display("FAIL buf_write_en: got %b expected %b at %0t", buf_write_en_o, exp_wr,
                     $time);
        end
        last_wr = (buf_write_en_o === 1'b1);
        if (last_wr) begin
            last_wr_addr = buf_addr_o;
            last_wr_data = buf_instr_o;
            wr_count++;
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                checks++;
                if (buf_addr_o !== e.addr || buf_instr_o !== e.data) begin
                    errors++;
                    $display("FAIL push_data: got %h@%h expected %h@%h at %0t", buf_instr_o,
                             buf_addr_o, e.data, e.addr, $time);
                end
            end
        end
        last_req = acc;
        if (acc) last_req_addr = instr_addr_o;
        if (acc) begin
            p.addr  = instr_addr_o;
            p.stale = redir || pend_tgt_v;
            pend_q.push_back(p);
            if (redir) begin
                exp_addr   = {raddr[31:2], 2'b00};
                pend_tgt_v = 1'b0;
            end else if (pend_tgt_v) begin
                exp_addr   = pend_tgt;
                pend_tgt_v = 1'b0;
            end else begin
                exp_addr = exp_addr + 32'd4;
            end
        end else if (redir) begin
            if (instr_req_o === 1'b1) begin
                pend_tgt   = {raddr[31:2], 2'b00};
                pend_tgt_v = 1'b1;
            end else begin
                exp_addr = {raddr[31:2], 2'b00};
            end
        end
        checks++;
        if (pend_q.size() + exp_q.size() > MAXO) begin
            errors++;
            $display("FAIL bound: in flight %0d expected <= %0d at %0t",
                     pend_q.size() + exp_q.size(), MAXO, $time);
        end
        @(posedge clk);
        #1;
    endtask

    task automatic drain();
        gnt_en    = 1'b0;
        rvalid_en = 1'b1;
        full_en   = 1'b0;
        for (int i = 0; i < 20 && (pend_q.size() > 0 || exp_q.size() > 0); i++) tick(0, 0);
        checks++;
        if (pend_q.size() != 0 || exp_q.size() != 0) begin
            errors++;
            $display("FAIL drain_timeout: left %0d/%0d expected 0/0", pend_q.size(),
                     exp_q.size());
        end
    endtask

    task automatic wait_first_write(input logic [31:0] addr, input bit already);
        bit got;
        got = already;
        for (int i = 0; i < 10 && !got; i++) begin
            tick(0, 0);
            got = last_wr;
        end
        checks++;
        if (!got || last_wr_addr !== addr || last_wr_data !== mem_data(addr)) begin
            errors++;
            $display("FAIL first_push: got %b %h@%h expected 1 %h@%h", got, last_wr_data,
                     last_wr_addr, mem_data(addr), addr);
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        redirect_i = 1'b0; redirect_addr_i = '0; instr_gnt_i = 1'b0;
        instr_rvalid_i = 1'b0; instr_rdata_i = '0; buf_full_i = 1'b0;
        exp_addr = BOOT; pend_tgt_v = 1'b0; locked_m = 1'b0; wr_count = 0;
        #10;
        checks++;
        if (instr_req_o !== 1'b0 || buf_write_en_o !== 1'b0 || instr_addr_o !== BOOT) begin
            errors++;
            $display("FAIL reset_outputs: got req %b wr %b addr %h expected 0 0 %h",
                     instr_req_o, buf_write_en_o, instr_addr_o, BOOT);
        end
        @(posedge clk);
        #1;
        rst_n = 1'b1;
    endtask

    task automatic test_sequential();
        gnt_en = 1'b1; rvalid_en = 1'b1; full_en = 1'b0;
        for (int i = 0; i < 3; i++) begin
            tick(0, 0);
            checks++;
            if (!last_req || last_req_addr !== BOOT + 32'(4 * i)) begin
                errors++;
                $display("FAIL seq_req%0d: got %b %h expected 1 %h", i, last_req,
                         last_req_addr, BOOT + 32'(4 * i));
            end
        end
        wr_count = 0;
        repeat (8) tick(0, 0);
        checks++;
        if (wr_count != 8) begin
            errors++;
            $display("FAIL throughput: got %0d pushes expected 8", wr_count);
        end
    endtask

    task automatic test_buf_full();
        gnt_en = 1'b1; rvalid_en = 1'b1; full_en = 1'b1;
        wr_count = 0;
        repeat (10) tick(0, 0);
        checks++;
        if (wr_count != 0 || instr_req_o !== 1'b0) begin
            errors++;
            $display("FAIL full_hold: got pushes %0d req %b expected 0 0", wr_count,
                     instr_req_o);
        end
        full_en  = 1'b0;
        wr_count = 0;
        repeat (2) tick(0, 0);
        checks++;
        if (wr_count != 2) begin
            errors++;
            $display("FAIL full_release: got %0d pushes expected 2", wr_count);
        end
        repeat (3) tick(0, 0);
    endtask

    task automatic test_redirect();
        drain();
        gnt_en = 1'b1; rvalid_en = 1'b0;
        tick(0, 0);
        tick(0, 0);
        checks++;
        if (instr_req_o !== 1'b0) begin
            errors++;
            $display("FAIL two_outstanding: got req %b expected 0", instr_req_o);
        end
        rvalid_en = 1'b1;
        tick(1, 32'h0000_020A);
        tick(0, 0);
        checks++;
        if (!last_req || last_req_addr !== 32'h0000_0208) begin
            errors++;
            $display("FAIL redirect_req: got %b %h expected 1 00000208", last_req,
                     last_req_addr);
        end
        wait_first_write(32'h0000_0208, last_wr);
    endtask

    task automatic test_locked_redirect();
        logic [31:0] held;
        drain();
        gnt_en = 1'b0; rvalid_en = 1'b1;
        tick(0, 0);
        held = exp_addr;
        tick(1, 32'h0000_0400);
        tick(0, 0);
        tick(0, 0);
        gnt_en = 1'b1;
        tick(0, 0);
        checks++;
        if (!last_req || last_req_addr !== held) begin
            errors++;
            $display("FAIL locked_grant: got %b %h expected 1 %h", last_req, last_req_addr,
                     held);
        end
        tick(0, 0);
        checks++;
        if (!last_req || last_req_addr !== 32'h0000_0400) begin
            errors++;
            $display("FAIL locked_target: got %b %h expected 1 00000400", last_req,
                     last_req_addr);
        end
        wait_first_write(32'h0000_0400, last_wr);
    endtask

    task automatic test_rvalid_redirect();
        gnt_en = 1'b1; rvalid_en = 1'b1; full_en = 1'b0;
        repeat (3) tick(0, 0);
        tick(1, 32'h0000_0600);
        wait_first_write(32'h0000_0600, 1'b0);
    endtask

    task automatic test_wrap();
        gnt_en = 1'b1; rvalid_en = 1'b1; full_en = 1'b0;
        tick(1, 32'hFFFF_FFFC);
        tick(0, 0);
        checks++;
        if (!last_req || last_req_addr !== 32'hFFFF_FFFC) begin
            errors++;
            $display("FAIL wrap_first: got %b %h expected 1 fffffffc", last_req, last_req_addr);
        end
        tick(0, 0);
        checks++;
        if (!last_req || last_req_addr !== 32'h0000_0000) begin
            errors++;
            $display("FAIL wrap_next: got %b %h expected 1 00000000", last_req, last_req_addr);
        end
        repeat (4) tick(0, 0);
        drain();
    endtask

    initial begin
        test_reset();
        test_sequential();
        test_buf_full();
        test_redirect();
        test_locked_redirect();
        test_rvalid_redirect();
        test_wrap();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
